// File: rtl/mem_access_sched.sv
// Round-robin, release-time-gated scheduler sharing one RAM port among NUM_LANES delayed-access FIFOs.
// Grants are decided combinationally and registered; the granted lane is masked for one cycle while its FIFO head refreshes.
module mem_access_sched #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned TIME_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall_i,
    input  logic [TIME_W-1:0]             count,
    input  logic [NUM_LANES-1:0]          lane_valid,
    input  logic [NUM_LANES*TIME_W-1:0]   lane_out_time,
    input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
    output logic [NUM_LANES-1:0]          lane_pop,
    output logic                          RAM_en,
    output logic [ADDR_W-1:0]             RAM_Addr_o,
    output logic [$clog2(NUM_LANES)-1:0]  grant_lane,
    output logic                          late_o,
    output logic [15:0]                   late_cnt
);

    localparam int unsigned LW = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LANES-1:0]   r_pop;
    logic                   r_ram_en;
    logic [ADDR_W-1:0]      r_addr;
    logic [LW-1:0]          r_grant;
    logic                   r_late;
    logic [15:0]            r_late_cnt;
    logic [LW-1:0]          r_rr_ptr;
    logic [NUM_LANES-1:0]   r_mask;

    logic [TIME_W-1:0]      w_diff;
    logic [NUM_LANES-1:0]   w_due;
    logic [NUM_LANES-1:0]   w_late;
    logic [NUM_LANES-1:0]   w_elig;
    logic                   w_found;
    logic [LW-1:0]          w_gidx;
    logic [LW-1:0]          w_cand;
    logic                   w_grant;

    // Wrap-safe due test: the sign of (count - release) decides due/not-yet.
    always_comb begin
        w_diff = '0;
        w_due  = '0;
        w_late = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            w_diff    = count - lane_out_time[k*TIME_W +: TIME_W];
            w_due[k]  = ~w_diff[TIME_W-1];
            w_late[k] = w_due[k] && (w_diff != '0);
        end
    end

    assign w_elig = lane_valid & w_due & ~r_mask;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            w_cand = r_rr_ptr + LW'(i);
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        unique case (r_state)
            IDLE, ISSUE: begin
                if (stall_i) begin
                    w_state_nxt = STALL;
                end else if (w_found) begin
                    w_state_nxt = ISSUE;
                    w_grant     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            // Releasing the stall arbitrates in the same cycle.
            STALL: begin
                if (stall_i) begin
                    w_state_nxt = STALL;
                end else if (w_found) begin
                    w_state_nxt = ISSUE;
                    w_grant     = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pop      <= '0;
            r_ram_en   <= 1'b0;
            r_addr     <= '0;
            r_grant    <= '0;
            r_late     <= 1'b0;
            r_late_cnt <= '0;
            r_rr_ptr   <= '0;
            r_mask     <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pop    <= '0;
            r_ram_en <= 1'b0;
            r_late   <= 1'b0;
            r_mask   <= '0;
            if (w_grant) begin
                r_pop    <= NUM_LANES'(1) << w_gidx;
                r_ram_en <= 1'b1;
                r_addr   <= lane_addr[w_gidx*ADDR_W +: ADDR_W];
                r_grant  <= w_gidx;
                r_late   <= w_late[w_gidx];
                r_rr_ptr <= w_gidx + LW'(1);
                r_mask   <= NUM_LANES'(1) << w_gidx;
                if (w_late[w_gidx] && (r_late_cnt != '1)) begin
                    r_late_cnt <= r_late_cnt + 16'd1;
                end
            end
        end
    end

    assign lane_pop   = r_pop;
    assign RAM_en     = r_ram_en;
    assign RAM_Addr_o = r_addr;
    assign grant_lane = r_grant;
    assign late_o     = r_late;
    assign late_cnt   = r_late_cnt;

endmodule

// File: tb/tb_mem_access_sched.sv
// Directed bench for mem_access_sched: behavioural lane FIFOs feed the DUT and a queue of expected grants checks its issues.
module tb_mem_access_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic [15:0] count;
    logic [3:0]  lane_valid;
    logic [63:0] lane_out_time;
    logic [19:0] lane_addr;
    logic [3:0]  lane_pop;
    logic        RAM_en;
    logic [4:0]  RAM_Addr_o;
    logic [1:0]  grant_lane;
    logic        late_o;
    logic [15:0] late_cnt;

    mem_access_sched #(
        .NUM_LANES(4),
        .ADDR_W   (5),
        .TIME_W   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_i      (stall_i),
        .count        (count),
        .lane_valid   (lane_valid),
        .lane_out_time(lane_out_time),
        .lane_addr    (lane_addr),
        .lane_pop     (lane_pop),
        .RAM_en       (RAM_en),
        .RAM_Addr_o   (RAM_Addr_o),
        .grant_lane   (grant_lane),
        .late_o       (late_o),
        .late_cnt     (late_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [15:0] t;
        logic [4:0]  a;
    } ent_t;

    typedef struct {
        int         lane;
        logic [4:0] a;
        logic       late;
    } exp_t;

    ent_t        fifo[$];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        hold = 1'b0;
    logic        prev_en = 1'b0;
    logic [1:0]  prev_lane = 2'd0;
    logic [15:0] prev_count;
    logic [15:0] gcount[4];
    int          late_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_ent(input int lane, input logic [15:0] t, input logic [4:0] a);
        ent_t e;
        e.lane = lane;
        e.t    = t;
        e.a    = a;
        fifo.push_back(e);
    endtask

    task automatic push_exp(input int lane, input logic [4:0] a, input logic late);
        exp_t e;
        e.lane = lane;
        e.a    = a;
        e.late = late;
        sb.push_back(e);
    endtask

    task automatic pop_lane(input int lane);
        int idx;
        idx = -1;
        for (int i = 0; i < fifo.size(); i++) begin
            if (idx < 0 && fifo[i].lane == lane) idx = i;
        end
        if (idx >= 0) fifo.delete(idx);
    endtask

    task automatic drive();
        logic found;
        lane_valid    = '0;
        lane_out_time = '0;
        lane_addr     = '0;
        for (int k = 0; k < 4; k++) begin
            if (hold) begin
                lane_valid[k]            = 1'b1;
                lane_out_time[k*16 +: 16] = count - 16'd1;
                lane_addr[k*5 +: 5]       = 5'(k);
            end else begin
                found = 1'b0;
                for (int i = 0; i < fifo.size(); i++) begin
                    if (!found && fifo[i].lane == k) begin
                        found                     = 1'b1;
                        lane_valid[k]             = 1'b1;
                        lane_out_time[k*16 +: 16] = fifo[i].t;
                        lane_addr[k*5 +: 5]       = fifo[i].a;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] pops;
        exp_t       e;
        pops       = lane_pop;
        prev_count = count;
        @(posedge clk);
        #1;
        if (hold) begin
            if (RAM_en && late_o) late_seen++;
        end else begin
            if (RAM_en) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_issue", 32'(RAM_en), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_lane_pop", 32'(lane_pop), 32'(4'b0001 << e.lane));
                    chk("sb_grant_lane", 32'(grant_lane), 32'(e.lane));
                    chk("sb_addr", 32'(RAM_Addr_o), 32'(e.a));
                    chk("sb_late", 32'(late_o), 32'(e.late));
                    gcount[grant_lane] = prev_count;
                end
                if (prev_en) chk("rr_no_repeat", 32'(grant_lane != prev_lane), 32'h1);
            end
            prev_en   = RAM_en;
            prev_lane = grant_lane;
            for (int k = 0; k < 4; k++) begin
                if (pops[k]) pop_lane(k);
            end
        end
        count = count + 16'd1;
        drive();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        stall_i = 1'b0;
        hold    = 1'b0;
        fifo.delete();
        sb.delete();
        for (int k = 0; k < 4; k++) gcount[k] = 16'hDEAD;
        drive();
        repeat (2) tick();
        reset   = 1'b0;
        prev_en = 1'b0;
    endtask

    initial begin
        int  n;
        logic [15:0] c0;
        logic mid_done;
        reset   = 1'b1;
        stall_i = 1'b0;
        count   = 16'd0;
        drive();
        #3;
        chk("rst_lane_pop", 32'(lane_pop), 32'h0);
        chk("rst_ram_en", 32'(RAM_en), 32'h0);
        chk("rst_addr", 32'(RAM_Addr_o), 32'h0);
        chk("rst_grant", 32'(grant_lane), 32'h0);
        chk("rst_late", 32'(late_o), 32'h0);
        chk("rst_late_cnt", 32'(late_cnt), 32'h0);

        // single lane, release at count 20
        do_reset();
        count = 16'd10;
        push_ent(0, 16'd20, 5'd1);
        push_exp(0, 5'd1, 1'b0);
        drive();
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        chk("t1_grant_count", 32'(gcount[0]), 32'd20);
        repeat (3) tick();
        chk("t1_late_cnt", 32'(late_cnt), 32'h0);
        chk("t1_drain", 32'(sb.size()), 32'h0);

        // round robin over four due lanes, two entries each
        do_reset();
        c0 = count;
        for (int k = 0; k < 4; k++) begin
            push_ent(k, c0, 5'(k + 1));
            push_ent(k, c0, 5'(k + 1));
        end
        for (int i = 0; i < 8; i++) push_exp(i % 4, 5'((i % 4) + 1), i != 0);
        drive();
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("t2_drain", 32'(sb.size()), 32'h0);
        chk("t2_late_cnt", 32'(late_cnt), 32'd7);

        // wrap: late lane2 across 0xFFFF->0, lane1 released at 5
        do_reset();
        count = 16'hFFF0;
        push_ent(1, 16'd5, 5'd9);
        push_exp(2, 5'd7, 1'b1);
        push_exp(1, 5'd9, 1'b0);
        drive();
        for (int i = 0; i < 24; i++) begin
            if (count == 16'd1) begin
                push_ent(2, 16'hFFFE, 5'd7);
                drive();
            end
            tick();
        end
        chk("t3_lane2_count", 32'(gcount[2]), 32'd1);
        chk("t3_lane1_count", 32'(gcount[1]), 32'd5);
        chk("t3_late_cnt", 32'(late_cnt), 32'd1);
        chk("t3_drain", 32'(sb.size()), 32'h0);

        // stall holds address/lane, resumes at rr_ptr
        do_reset();
        push_ent(0, count, 5'd21);
        push_exp(0, 5'd21, 1'b0);
        drive();
        tick();
        chk("t4_pre_addr", 32'(RAM_Addr_o), 32'd21);
        stall_i = 1'b1;
        c0 = count;
        push_ent(1, c0, 5'd11);
        push_ent(3, c0, 5'd13);
        push_exp(1, 5'd11, 1'b1);
        push_exp(3, 5'd13, 1'b1);
        drive();
        repeat (5) begin
            tick();
            chk("t4_stall_en", 32'(RAM_en), 32'h0);
            chk("t4_stall_pop", 32'(lane_pop), 32'h0);
            chk("t4_stall_addr", 32'(RAM_Addr_o), 32'd21);
            chk("t4_stall_grant", 32'(grant_lane), 32'h0);
        end
        stall_i = 1'b0;
        tick();
        chk("t4_resume_en", 32'(RAM_en), 32'h1);
        chk("t4_resume_lane", 32'(grant_lane), 32'd1);
        tick();
        chk("t4_second_lane", 32'(grant_lane), 32'd3);
        chk("t4_late_cnt", 32'(late_cnt), 32'd2);
        chk("t4_drain", 32'(sb.size()), 32'h0);

        // async reset while lanes 0/1 issue back-to-back
        do_reset();
        c0 = count - 16'd1;
        for (int i = 0; i < 3; i++) begin
            push_ent(0, c0, 5'h10);
            push_ent(1, c0, 5'h11);
        end
        push_exp(0, 5'h10, 1'b1);
        drive();
        tick();
        chk("t5_pre_late_cnt", 32'(late_cnt), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_en", 32'(RAM_en), 32'h0);
        chk("t5_rst_pop", 32'(lane_pop), 32'h0);
        chk("t5_rst_addr", 32'(RAM_Addr_o), 32'h0);
        chk("t5_rst_grant", 32'(grant_lane), 32'h0);
        chk("t5_rst_late", 32'(late_o), 32'h0);
        chk("t5_rst_late_cnt", 32'(late_cnt), 32'h0);
        do_reset();
        c0 = count;
        push_ent(0, c0, 5'h10);
        push_ent(1, c0, 5'h11);
        push_exp(0, 5'h10, 1'b0);
        push_exp(1, 5'h11, 1'b1);
        drive();
        tick();
        chk("t5_restart_en", 32'(RAM_en), 32'h1);
        chk("t5_restart_lane", 32'(grant_lane), 32'h0);
        tick();
        repeat (2) tick();
        chk("t5_drain", 32'(sb.size()), 32'h0);

        // late_cnt saturation over 65536+3 late issues
        do_reset();
        hold = 1'b1;
        drive();
        late_seen = 0;
        mid_done  = 1'b0;
        n = 0;
        while (late_seen < 65539 && n < 70000) begin
            tick();
            n++;
            if (late_seen == 65534 && !mid_done) begin
                chk("t6_cnt_fffe", 32'(late_cnt), 32'hFFFE);
                mid_done = 1'b1;
            end
        end
        chk("t6_issue_budget", 32'(late_seen), 32'd65539);
        chk("t6_saturated", 32'(late_cnt), 32'hFFFF);
        hold = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
